// File: rtl/mat_frobenius_scale.sv
// mat_frobenius_scale
// Produces the Frobenius norm of a SIZE_A x SIZE_B signed matrix. This value is
// the scale operand for scalar_divide_mat, and it is never zero.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, honoured only while idle
//   matrix     signed elements, captured on the accepting edge
//   scale      unsigned norm, held until the next result
//   done       one-cycle pulse when scale/flags are updated
//   busy       high from the accepting edge until the edge raising done
//   zero_flag  last sum of squares was zero (scale forced to 1)
//   sat_flag   last root exceeded N_BITS and was clipped
module mat_frobenius_scale #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_BITS-1:0] matrix [SIZE_A][SIZE_B],
    output logic [N_BITS-1:0] scale,
    output logic              done,
    output logic              busy,
    output logic              zero_flag,
    output logic              sat_flag
);

    localparam int NE    = SIZE_A * SIZE_B;
    localparam int ACC_W = 2 * N_BITS + $clog2(NE);
    localparam int SQ_W  = (ACC_W + 1) / 2;
    localparam int RAD_W = 2 * SQ_W;
    localparam int RW    = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int CW    = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam int CNT_W = (SQ_W > 1) ? $clog2(SQ_W) : 1;
    localparam int MAX_W = ((SQ_W > N_BITS) ? SQ_W : N_BITS) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SQRT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state;
    logic [N_BITS-1:0]   snap [SIZE_A][SIZE_B];
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic [ACC_W-1:0]    acc;
    logic [RAD_W-1:0]    rad;
    logic [SQ_W+1:0]     rem;
    logic [SQ_W-1:0]     root;
    logic [CNT_W-1:0]    cnt;

    logic signed [N_BITS-1:0] elem;
    logic [2*N_BITS-1:0]      prod;
    logic [ACC_W-1:0]         acc_next;
    logic [SQ_W+1:0]          rem_sh;
    logic [SQ_W+1:0]          trial;
    logic                     ge;
    logic                     over;

    always_comb begin
        elem     = signed'(snap[row][col]);
        // The square of a signed value is non-negative, so it can be zero-extended.
        prod     = unsigned'((2*N_BITS)'(elem) * (2*N_BITS)'(elem));
        acc_next = acc + ACC_W'(prod);
        // Restoring root step: bring in the next two radicand bits and try root*4+1.
        rem_sh   = {rem[SQ_W-1:0], rad[RAD_W-1 -: 2]};
        trial    = {root, 2'b01};
        ge       = (rem_sh >= trial);
        over     = (MAX_W'(root) > MAX_W'({N_BITS{1'b1}}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            snap      <= '{default: '0};
            row       <= '0;
            col       <= '0;
            acc       <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            scale     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            zero_flag <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap  <= matrix;
                        acc   <= '0;
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_next;
                    if (col == CW'(SIZE_B - 1)) begin
                        col <= '0;
                        if (row == RW'(SIZE_A - 1)) begin
                            // The root shifts a separate copy of the sum, so acc
                            // stays intact for the zero test in DONE.
                            rad   <= RAD_W'(acc_next);
                            rem   <= '0;
                            root  <= '0;
                            cnt   <= '0;
                            state <= S_SQRT;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                S_SQRT: begin
                    rad  <= {rad[RAD_W-3:0], 2'b00};
                    rem  <= ge ? (rem_sh - trial) : rem_sh;
                    root <= {root[SQ_W-2:0], ge};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(SQ_W - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (over) begin
                        scale     <= '1;
                        sat_flag  <= 1'b1;
                        zero_flag <= 1'b0;
                    end else if (acc == '0) begin
                        scale     <= N_BITS'(1);
                        sat_flag  <= 1'b0;
                        zero_flag <= 1'b1;
                    end else begin
                        scale     <= N_BITS'(root);
                        sat_flag  <= 1'b0;
                        zero_flag <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mat_frobenius_scale.md
# mat_frobenius_scale

Sequential normalisation-scale generator feeding `scalar_divide_mat`. It snapshots an SIZE_A×SIZE_B matrix, accumulates the sum of squared elements one element per cycle, then takes an integer square root bit-serially. It presents the Frobenius norm as the `scale` operand, so the downstream divider produces a unit-norm matrix. The block guarantees a non-zero `scale`, so the divider never sees a divide-by-zero.

## Interface
- SIZE_A, 8, matrix rows
- SIZE_B, 8, matrix columns
- N_BITS, 22, element and scale width
- Derived constants (localparam):
  - ACC_W = 2*N_BITS + $clog2(SIZE_A*SIZE_B), 50 at defaults
  - SQ_W = ceil(ACC_W/2), 25 at defaults

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- matrix  in  N_BITS [SIZE_A][SIZE_B]  elements, two's complement signed; sampled on the start-accepting edge only
- scale  out  N_BITS  unsigned norm, held stable until the next accepted start completes
- done  out  1  one-cycle pulse when `scale` is updated
- busy  out  1  high from the start-accepting edge until the edge that raises done
- zero_flag  out  1  last result had sum of squares = 0
- sat_flag  out  1  last result was clipped to the N_BITS maximum

## Operation
- States: IDLE, ACCUM, SQRT, DONE.
- IDLE, start=1:
  - copy `matrix` into an internal snapshot register
  - clear the accumulator and element index
  - set busy; go to ACCUM
- IDLE, start=0: hold.
- ACCUM:
  - one element per cycle, row-major order (index = i*SIZE_B + j)
  - acc += elem*elem; signed multiply, result zero-extended to ACC_W
  - after element SIZE_A*SIZE_B-1, go to SQRT
- SQRT:
  - restoring bit-by-bit integer square root of acc
  - one result bit per cycle, MSB first, SQ_W cycles
  - result = floor(sqrt(acc))
  - then go to DONE
- DONE (one cycle):
  - result > 2^N_BITS-1: scale = 2^N_BITS-1, sat_flag=1
  - else if acc = 0: scale = 1, zero_flag=1
  - else: scale = result, both flags 0
  - done=1, busy=0; return to IDLE
- Flags are rewritten on every DONE and held between results.
- start while busy: ignored, no queuing. `matrix` may change freely after acceptance.
- Arithmetic is never wrapped: ACC_W holds SIZE_A*SIZE_B*(2^(N_BITS-1))^2 exactly.

## Timing
- Reset (rst_n=0, asynchronous, any state, including mid-ACCUM or mid-SQRT):
  - state=IDLE, scale=0, done=0, busy=0, zero_flag=0, sat_flag=0
  - accumulator, index and snapshot cleared
  - in-flight computation discarded; no done pulse
- First start is accepted on the first rising edge with rst_n=1 and start=1.
- Latency:
  - start accepted on edge k; busy high from k
  - ACCUM occupies edges k+1 … k+SIZE_A*SIZE_B
  - SQRT occupies the next SQ_W edges
  - DONE registers on edge k + SIZE_A*SIZE_B + SQ_W + 1 (k+90 at defaults): done=1, busy=0, scale and flags valid from that edge
- done falls on the following edge. The earliest next start is accepted on that same following edge, because state is IDLE by then.
- Throughput: one result per SIZE_A*SIZE_B + SQ_W + 2 cycles when start is held high.
- Before the first result after reset, scale=0; the downstream divider must not be enabled until done.

## Test plan
- Identity 8×8 (diagonal 1, rest 0), start pulse → done at start+90; scale=2 (sum 8); both flags 0; busy high for exactly 90 cycles.
- All elements 3 → sum 576; scale=24. Repeat with all elements -3 → identical result (sign-insensitive).
- All elements 0 → scale=1, zero_flag=1, sat_flag=0.
- All elements -2^21 → sum 2^48, sqrt 2^24 → scale=0x3FFFFF, sat_flag=1. Element 0 = 1000, rest 0 → scale=1000, sat_flag cleared.
- start held high continuously, with `matrix` changed during busy → each result uses only the matrix sampled at acceptance; consecutive done pulses 91 cycles apart; no extra starts accepted.
- rst_n pulled low at start+40 (mid-ACCUM) → all outputs 0 immediately, without waiting for a clock edge; no done pulse. A fresh start with all elements 3 after release → scale=24 at start+90.
